// File: rtl/multicycle_sequencer.sv
// Multicycle datapath state sequencer: fetch/decode/execute walk with mem handshake.
// Optional illegal-opcode trap state enabled by defining SEQ_ILLEGAL_TRAP_EN.
module multicycle_sequencer #(
    parameter logic [5:0] OP_LDI  = 6'h10,
    parameter logic [5:0] OP_LD   = 6'h20,
    parameter logic [5:0] OP_STR  = 6'h21,
    parameter logic [5:0] OP_BEQ  = 6'h30,
    parameter logic [5:0] OP_JUMP = 6'h38
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic [3:0]  state,
    output logic        mem_req,
    output logic        ir_write,
    output logic        retire,
`ifdef SEQ_ILLEGAL_TRAP_EN
    output logic        trap,
`endif
    output logic [15:0] retired_count
);

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_RF      = 4'd1,
        S_IMM3    = 4'd2,
        S_ALU_R3  = 4'd3,
        S_ALU_RI3 = 4'd4,
        S_ALU4    = 4'd5,
        S_BRANCH3 = 4'd6,
        S_MEM3    = 4'd7,
        S_LOAD4   = 4'd8,
        S_STORE4  = 4'd9,
        S_LOAD5   = 4'd10,
        S_JUMP3   = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    state_t st;
    state_t nxt;
    state_t rf_nxt;
    logic   done;
    logic   illegal;

    assign state    = st;
    assign mem_req  = (st == S_IF) || (st == S_LOAD4) || (st == S_STORE4);
    assign ir_write = (st == S_IF) && mem_ready && !rst;

    // Opcode dispatch out of register fetch
    always_comb begin
        rf_nxt  = S_IF;
        illegal = 1'b0;
        if (opcode[5:3] == 3'b000) begin
            rf_nxt = S_ALU_R3;
        end else if (opcode[5:3] == 3'b001) begin
            rf_nxt = S_ALU_RI3;
        end else if (opcode == OP_LDI) begin
            rf_nxt = S_IMM3;
        end else if (opcode == OP_BEQ) begin
            rf_nxt = S_BRANCH3;
        end else if (opcode == OP_LD || opcode == OP_STR) begin
            rf_nxt = S_MEM3;
        end else if (opcode == OP_JUMP) begin
            rf_nxt = S_JUMP3;
        end else begin
            illegal = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
            rf_nxt  = S_TRAP;
`else
            rf_nxt  = S_IF;
`endif
        end
    end

    always_comb begin
        nxt  = st;
        done = 1'b0;
        case (st)
            S_IF: begin
                if (mem_ready) nxt = S_RF;
            end
            S_RF: begin
                nxt = rf_nxt;
`ifndef SEQ_ILLEGAL_TRAP_EN
                done = illegal;
`endif
            end
            S_ALU_R3, S_ALU_RI3: nxt = S_ALU4;
            S_ALU4, S_IMM3, S_BRANCH3, S_JUMP3, S_LOAD5: begin
                nxt  = S_IF;
                done = 1'b1;
            end
            S_MEM3: nxt = (opcode == OP_LD) ? S_LOAD4 : S_STORE4;
            S_LOAD4: begin
                if (mem_ready) nxt = S_LOAD5;
            end
            S_STORE4: begin
                if (mem_ready) begin
                    nxt  = S_IF;
                    done = 1'b1;
                end
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            S_TRAP: nxt = S_TRAP;
`endif
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= S_IF;
            retire        <= 1'b0;
            retired_count <= 16'd0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            trap          <= 1'b0;
`endif
        end else begin
            st     <= nxt;
            retire <= done;
            if (done) retired_count <= retired_count + 16'd1;
`ifdef SEQ_ILLEGAL_TRAP_EN
            trap   <= (nxt == S_TRAP);
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed-vector bench for multicycle_sequencer.
// Covers dispatch paths, memory waits, mid-instruction reset, illegal opcode, counter wrap.
module tb_multicycle_sequencer;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  state;
    logic        mem_req;
    logic        ir_write;
    logic        retire;
    logic [15:0] retired_count;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic        trap;
`endif

    int nvec = 0;
    int nmis = 0;

    multicycle_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .state         (state),
        .mem_req       (mem_req),
        .ir_write      (ir_write),
        .retire        (retire),
`ifdef SEQ_ILLEGAL_TRAP_EN
        .trap          (trap),
`endif
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk n cycles; expected states packed as nibbles, first one in bits [3:0]
    task automatic walk(input string tag, input int n, input logic [31:0] seq);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s_s%0d", tag, i), 32'(state),
                  32'((seq >> (4 * i)) & 32'hF));
        end
    endtask

    task automatic retired(input string tag, input logic [15:0] cnt);
        check({tag, "_ret"}, 32'(retire), 32'd1);
        check({tag, "_cnt"}, 32'(retired_count), 32'(cnt));
    endtask

    initial begin
        rst = 1'b1;
        opcode = 6'h00;
        mem_ready = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_cnt", 32'(retired_count), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_irw", 32'(ir_write), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_memreq", 32'(mem_req), 32'd1);

        tick();
        check("if_wait", 32'(state), 32'd0);
        check("if_wait_irw", 32'(ir_write), 32'd0);

        // ADD: 0,1,3,5,0
        opcode = 6'h00;
        mem_ready = 1'b1;
        #1;
        check("add_irw", 32'(ir_write), 32'd1);
        walk("add", 4, 32'h0531);
        retired("add", 16'd1);

        // ALU-immediate: 0,1,4,5,0
        opcode = 6'h0B;
        walk("alui", 1, 32'h1);
        check("alui_ret0", 32'(retire), 32'd0);
        walk("alui2", 3, 32'h054);
        retired("alui", 16'd2);

        // BEQ: 0,1,6,0
        opcode = 6'h30;
        walk("beq", 3, 32'h061);
        retired("beq", 16'd3);

        // LD with two wait cycles in LOAD4
        opcode = 6'h20;
        walk("ld", 3, 32'h871);
        mem_ready = 1'b0;
        #1;
        check("ld_memreq", 32'(mem_req), 32'd1);
        walk("ld_w", 2, 32'h88);
        check("ld_memreq2", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        walk("ld_e", 2, 32'h0A);
        retired("ld", 16'd4);

        // STR then JUMP back-to-back
        opcode = 6'h21;
        walk("str", 4, 32'h0971);
        retired("str", 16'd5);
        opcode = 6'h38;
        walk("jmp", 1, 32'h1);
        check("jmp_ret0", 32'(retire), 32'd0);
        walk("jmp2", 2, 32'h0B);
        retired("jmp", 16'd6);

        // Reset while LOAD4 waits on memory
        opcode = 6'h20;
        walk("rld", 3, 32'h871);
        mem_ready = 1'b0;
        tick();
        rst = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("rmid_state", 32'(state), 32'd0);
        check("rmid_cnt", 32'(retired_count), 32'd0);
        check("rmid_ret", 32'(retire), 32'd0);
        check("rmid_irw", 32'(ir_write), 32'd0);
        rst = 1'b0;
        opcode = 6'h10;
        walk("ldi", 3, 32'h021);
        retired("ldi", 16'd1);

        // Illegal opcode
        opcode = 6'h3F;
`ifdef SEQ_ILLEGAL_TRAP_EN
        walk("ill", 2, 32'hC1);
        check("ill_trap", 32'(trap), 32'd1);
        check("ill_memreq", 32'(mem_req), 32'd0);
        repeat (10) tick();
        check("ill_hold", 32'(state), 32'd12);
        check("ill_trap2", 32'(trap), 32'd1);
        check("ill_ret", 32'(retire), 32'd0);
        check("ill_cnt", 32'(retired_count), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ill_rst_st", 32'(state), 32'd0);
        check("ill_rst_trap", 32'(trap), 32'd0);
        check("ill_rst_cnt", 32'(retired_count), 32'd0);
`else
        walk("ill", 2, 32'h01);
        retired("ill", 16'd2);
`endif

        // Counter wrap: preload while parked in IF
        mem_ready = 1'b0;
        tick();
        force dut.retired_count = 16'hFFFF;
        tick();
        release dut.retired_count;
        tick();
        check("wrap_pre", 32'(retired_count), 32'h0000FFFF);
        opcode = 6'h10;
        mem_ready = 1'b1;
        walk("wrap", 3, 32'h021);
        retired("wrap", 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Next-state controller for the multicycle datapath. It walks the instruction state sequence (fetch, register fetch, execute, memory, writeback) based on the current opcode. It waits on a memory ready handshake and drives the 4-bit `state` bus into the control decoder, which generates the datapath control signals. It also produces instruction-register write and retire strobes and keeps a retired-instruction counter.

## Interface
- `OP_LDI`, default 6'h10: load-immediate opcode.
- `OP_LD`, default 6'h20: load-word opcode.
- `OP_STR`, default 6'h21: store-word opcode.
- `OP_BEQ`, default 6'h30: branch-if-equal opcode.
- `OP_JUMP`, default 6'h38: jump opcode.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 6: opcode field of the latched instruction register. Must be stable from RF through the end of the instruction.
- `mem_ready` input 1: memory completion. Sampled only while `mem_req`=1.
- `state` output 4: current control state, sent to the control decoder.
- `mem_req` output 1: memory access outstanding.
- `ir_write` output 1: one-cycle strobe; latch the fetched instruction.
- `retire` output 1: one-cycle strobe; instruction completed.
- `retired_count` output 16: count of retired instructions.
- `trap` output 1: illegal-opcode flag. Present only with `SEQ_ILLEGAL_TRAP_EN`.

## Operation
- State encoding:
  - 0 IF, 1 RF, 2 IMM3, 3 ALU_R3, 4 ALU_RI3, 5 ALU4
  - 6 BRANCH3, 7 MEM3, 8 LOAD4, 9 STORE4, 10 LOAD5, 11 JUMP3, 12 TRAP
  - Codes 13–15 are unreachable; if entered, the next state is IF.
- Opcode classes:
  - R-type: `opcode[5:3]`=3'b000.
  - ALU-immediate: `opcode[5:3]`=3'b001.
  - The five parameter opcodes as listed.
  - Everything else is illegal.
- Transitions:
  - IF: `mem_req`=1. Stay until `mem_ready`; then `ir_write`=1 in that cycle and go to RF.
  - RF, dispatch by opcode:
    - LDI → IMM3
    - R-type → ALU_R3
    - ALU-immediate → ALU_RI3
    - BEQ → BRANCH3
    - LD or STR → MEM3
    - JUMP → JUMP3
    - illegal → see Configuration
  - ALU_R3 and ALU_RI3 → ALU4. ALU4 → IF (retire).
  - IMM3, BRANCH3, JUMP3 → IF (retire).
  - MEM3 → LOAD4 if `opcode`==`OP_LD`, else STORE4.
  - LOAD4: `mem_req`=1. Wait for `mem_ready`, then go to LOAD5. LOAD5 → IF (retire).
  - STORE4: `mem_req`=1. Wait for `mem_ready`, then go to IF (retire).
- `mem_req` is combinational from state: 1 exactly in IF, LOAD4 and STORE4.
- `mem_ready` is ignored in all other states.
- `retire` is registered and asserts in the first IF cycle after a completing state.
- `retired_count` increments by 1 on each retire and wraps from 16'hFFFF to 0.
- Reset (including in the middle of an instruction, even with a memory access pending):
  - `state`=IF, `retired_count`=0, `ir_write`=0, `retire`=0, `trap`=0.
  - `mem_req` therefore reads 1 in the cycle after reset.
  - An in-flight instruction is abandoned and not counted.

## Timing
- With zero wait states (`mem_ready` high when requested), instruction latency in cycles, IF to next IF:
  - LDI, BEQ, JUMP: 3
  - R-type, ALU-immediate: 4
  - STR: 4
  - LD: 5
- Each low `mem_ready` cycle in IF, LOAD4 or STORE4 adds one cycle.
- `ir_write` and `mem_ready` are in the same cycle.
- `retire` is high the cycle after the last execute state.
- `retired_count` updates in the same edge that raises `retire`.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in RF goes to TRAP.
  - TRAP is absorbing until `rst`; `trap`=1 while in it.
  - No retire; `mem_req`=0.
- `SEQ_ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode in RF goes to IF and retires as a NOP.
  - The `trap` port does not exist; state 12 is unreachable.

## Test plan
- ADD (6'h00), `mem_ready` tied 1: states 0,1,3,5,0. `ir_write` in cycle 1, `retire` in cycle 5, count=1.
- LD, `mem_ready` low for 2 cycles in LOAD4: states 0,1,7,8,8,8,10,0. `mem_req` high in 0 and in all three LOAD4 cycles.
- STR then JUMP back-to-back: states 0,1,7,9,0,1,11,0. Two `retire` pulses, count=2.
- `rst` asserted during LOAD4 wait: next state 0, count=0, no `retire`. The following fetch proceeds normally.
- Opcode 6'h3F in RF:
  - Macro defined: state 12 and `trap`=1, held for 10 cycles until `rst`.
  - Macro undefined: returns to 0, count increments.
- Preload 65535 retirements (forced or run): next retire wraps `retired_count` to 0.
